// File: rtl/rca_seq_adder_pkg.sv
// rca_seq_adder_pkg: slice width, controller state encodings and index sizing for rca_seq_adder
package rca_seq_adder_pkg;
    localparam int SLICE_W = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rca_seq_adder_rca.sv
// rca_seq_adder_rca: 4-bit ripple-carry slice shared by every chunk of the wide add
module rca_seq_adder_rca
    import rca_seq_adder_pkg::*;
(
    output logic               Cout,
    output logic [SLICE_W-1:0] S,
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin
);
    logic [SLICE_W:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Cout = c[SLICE_W];
endmodule

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle WIDTH-bit add/sub, one 4-bit chunk per clock through a single slice
module rca_seq_adder
    import rca_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNKS = WIDTH / SLICE_W;
    localparam int IW     = idx_width(CHUNKS);

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [SLICE_W-1:0] s;
    logic               c, last;

    rca_seq_adder_rca u_rca (
        .Cout (c),
        .S    (s),
        .A    (a_q[idx_q*SLICE_W +: SLICE_W]),
        .B    (b_q[idx_q*SLICE_W +: SLICE_W]),
        .Cin  (carry_q)
    );

    assign last = (idx_q == IW'(CHUNKS - 1));

    // b is stored pre-inverted so subtraction is a + ~b + 1 through the same slice
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE && start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            idx_d   = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = s;
            carry_d = c;
            idx_d   = last ? '0 : idx_q + 1'b1;
            if (last) begin
                cout_d  = c;
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[SLICE_W-1] != a_q[WIDTH-1]);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end else if (state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: randomized and directed checks of rca_seq_adder (WIDTH=16 and WIDTH=4) against an arithmetic model
module tb_rca_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    rca_seq_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    rca_seq_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // returns {ovf, cout, sum} from plain integer arithmetic on w-bit operands
    function automatic logic [17:0] model(input int w, input logic [15:0] xa, input logic [15:0] xb,
                                          input logic xs, input logic xc);
        longint m, h, ua, ub, sa, sb, t, sr;
        logic [17:0] r;
        m  = longint'(1) << w;
        h  = m / 2;
        ua = longint'(xa) & (m - 1);
        ub = longint'(xb) & (m - 1);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        r  = '0;
        if (xs) begin
            t     = ua - ub;
            r[16] = (ua >= ub);
            sr    = sa - sb;
        end else begin
            t     = ua + ub + longint'(xc);
            r[16] = (t >= m);
            sr    = sa + sb + longint'(xc);
        end
        r[15:0] = 16'(t & (m - 1));
        r[17]   = (sr >= h) || (sr < -h);
        return r;
    endfunction

    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input logic xc,
                         input bit poke);
        logic [17:0] e;
        e = model(16, xa, xb, xs, xc);
        @(negedge clk);
        a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        chk("busy_accept", busy, 1);
        chk("done_accept", done, 0);
        for (int i = 1; i <= 4; i++) begin
            if (poke && i == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("busy_run", busy, 1);
            chk("done_timing", done, 32'(i == 4));
        end
        chk("sum", sum, e[15:0]);
        chk("cout", cout, e[16]);
        chk("ovf", ovf, e[17]);
        @(posedge clk);
        #1;
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
        chk("sum_hold", sum, e[15:0]);
    endtask

    task automatic run4(input logic [3:0] xa, input logic [3:0] xb, input logic xs, input logic xc);
        logic [17:0] e;
        e = model(4, 16'(xa), 16'(xb), xs, xc);
        @(negedge clk);
        a4 = xa; b4 = xb; sub4 = xs; cin4 = xc; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("w4_done_accept", done4, 0);
        chk("w4_busy_accept", busy4, 1);
        @(posedge clk);
        #1;
        chk("w4_done", done4, 1);
        chk("w4_sum", sum4, e[3:0]);
        chk("w4_cout", cout4, e[16]);
        chk("w4_ovf", ovf4, e[17]);
        @(posedge clk);
        #1;
        chk("w4_idle", busy4 | done4, 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run16(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        run16(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 30; n++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));

        run16(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hABCD; b = 16'h1357; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_flags", {cout, ovf}, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run16(16'hABCD, 16'h1357, 1'b0, 1'b1, 1'b0);

        run4(4'hF, 4'h1, 1'b0, 1'b1);
        run4(4'h7, 4'h1, 1'b0, 1'b0);
        run4(4'h8, 4'h1, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++)
            run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
